predictor_branch_table: RTL

Front end of the branch prediction path. It holds a table of 2-bit saturating counters indexed by fetch address and issues a taken/not-taken prediction and a next-fetch address for every fetched branch. It tracks outstanding predictions in a small in-order queue. It consumes the resolution (branch_result, prediction_failed) produced downstream to train the table and flush wrong-path branches.

---
 rtl/predictor_branch_table.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/predictor_branch_table.sv
// Branch prediction front end: a 2-bit saturating counter table indexed by fetch address,
// plus an in-order queue of outstanding prediction indices that is trained and flushed on resolve.
module predictor_branch_table #(
    parameter int unsigned INDEX_BITS  = 4,
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter logic [1:0]  INIT_STATE  = 2'b01
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           fetch_valid,
    input  logic                           fetch_is_branch,
    input  logic [10:0]                    fetch_addr,
    input  logic [10:0]                    fetch_jump_addr,
    output logic                           stall,
    output logic                           predict_valid,
    output logic                           branch_taken,
    output logic [10:0]                    next_addr,
    input  logic                           resolve_valid,
    input  logic                           branch_result,
    input  logic                           prediction_failed,
    output logic [$clog2(QUEUE_DEPTH):0]   pending_count,
    output logic                           resolve_error
);

    localparam int unsigned ENTRIES  = 1 << INDEX_BITS;
    localparam int unsigned PTR_BITS = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_BITS = PTR_BITS + 1;

    localparam logic [PTR_BITS-1:0] PTR_ONE  = PTR_BITS'(1);
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(QUEUE_DEPTH);

    if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("QUEUE_DEPTH must be a power of 2 and at least 2");
    end

    logic [1:0]            table_q [ENTRIES];
    logic [INDEX_BITS-1:0] queue_q [QUEUE_DEPTH];

    logic [PTR_BITS-1:0]   head_q, head_d;
    logic [PTR_BITS-1:0]   tail_q, tail_d;
    logic [CNT_BITS-1:0]   count_q, count_d;

    logic                  predict_valid_q;
    logic                  branch_taken_q, branch_taken_d;
    logic [10:0]           next_addr_q, next_addr_d;
    logic                  resolve_error_q;

    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  flush;
    logic                  push_accept;

    logic [INDEX_BITS-1:0] fetch_idx;
    logic [1:0]            pred_cnt;
    logic [INDEX_BITS-1:0] head_idx;
    logic [1:0]            head_cnt;
    logic [1:0]            upd_cnt;

    assign full        = (count_q == CNT_FULL);
    assign push        = fetch_valid & fetch_is_branch & ~full;
    assign pop         = resolve_valid & (count_q != '0);
    assign flush       = resolve_valid & prediction_failed;
    // A flush kills the wrong-path branch fetched in the same cycle.
    assign push_accept = push & ~flush;

    assign fetch_idx = fetch_addr[INDEX_BITS-1:0];
    assign pred_cnt  = table_q[fetch_idx];
    assign head_idx  = queue_q[head_q];
    assign head_cnt  = table_q[head_idx];

    always_comb begin
        upd_cnt = head_cnt;
        if (branch_result) begin
            if (head_cnt != 2'b11) begin
                upd_cnt = head_cnt + 2'd1;
            end
        end else if (head_cnt != 2'b00) begin
            upd_cnt = head_cnt - 2'd1;
        end
    end

    // Prediction reads the pre-update counter; a same-cycle update is not bypassed.
    always_comb begin
        branch_taken_d = branch_taken_q;
        next_addr_d    = next_addr_q;
        if (push_accept) begin
            branch_taken_d = pred_cnt[1];
            next_addr_d    = pred_cnt[1] ? fetch_jump_addr : fetch_addr + 11'd1;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop) begin
                head_d = head_q + PTR_ONE;
            end
            if (push_accept) begin
                tail_d = tail_q + PTR_ONE;
            end
            case ({push_accept, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= INIT_STATE;
            end
        end else if (pop) begin
            table_q[head_idx] <= upd_cnt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                queue_q[i] <= '0;
            end
        end else if (push_accept) begin
            queue_q[tail_q] <= fetch_idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            predict_valid_q <= 1'b0;
            branch_taken_q  <= 1'b0;
            next_addr_q     <= '0;
            resolve_error_q <= 1'b0;
        end else begin
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            predict_valid_q <= push_accept;
            branch_taken_q  <= branch_taken_d;
            next_addr_q     <= next_addr_d;
            resolve_error_q <= resolve_error_q | (resolve_valid & (count_q == '0));
        end
    end

    assign stall         = full;
    assign predict_valid = predict_valid_q;
    assign branch_taken  = branch_taken_q;
    assign next_addr     = next_addr_q;
    assign pending_count = count_q;
    assign resolve_error = resolve_error_q;

endmodule
